booth: RTL and testbench

BOOTH -- requirements
Module: booth

---
 rtl/booth.sv | 61 ++++++
 tb/tb_booth.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/booth.sv
// Radix-2 Booth multiplier for 4-bit signed operands producing an 8-bit signed product.
// Performs one Booth iteration per clock while start is high; start low reloads the operands.
module booth (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] input1,
    input  logic [3:0] input2,
    input  logic       start,
    output logic [7:0] result,
    output logic [2:0] count
);

    logic [4:0] a;
    logic [3:0] q;
    logic       q1;
    logic [4:0] m;
    logic [2:0] cnt;

    logic [4:0] sum;
    logic [4:0] a_next;
    logic [3:0] q_next;
    logic       q1_next;

    // The accumulator is one bit wider than the operands so that subtracting M = -8 stays exact.
    always_comb begin
        sum = a;
        case ({q[0], q1})
            2'b01:   sum = a + m;
            2'b10:   sum = a - m;
            default: sum = a;
        endcase
        a_next  = {sum[4], sum[4:1]};
        q_next  = {sum[0], q[3:1]};
        q1_next = q[0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a   <= 5'd0;
            q   <= 4'd0;
            q1  <= 1'b0;
            m   <= 5'd0;
            cnt <= 3'd0;
        end else if (!start) begin
            a   <= 5'd0;
            q   <= input2;
            q1  <= 1'b0;
            m   <= {input1[3], input1};
            cnt <= 3'd0;
        end else if (cnt < 3'd4) begin
            a   <= a_next;
            q   <= q_next;
            q1  <= q1_next;
            cnt <= cnt + 3'd1;
        end
    end

    assign result = {a[3:0], q};
    assign count  = cnt;

endmodule

// File: tb/tb_booth.sv
// Directed self-checking bench for the booth multiplier; expected values are hand-computed.
module tb_booth;

    logic       clk;
    logic       reset;
    logic [3:0] input1;
    logic [3:0] input2;
    logic       start;
    logic [7:0] result;
    logic [2:0] count;

    int checks;
    int failures;

    booth dut (
        .clk   (clk),
        .reset (reset),
        .input1(input1),
        .input2(input2),
        .start (start),
        .result(result),
        .count (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_and_run(input logic [3:0] x, input logic [3:0] y);
        start  = 1'b0;
        input1 = x;
        input2 = y;
        tick();
        start = 1'b1;
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        start  = 1'b0;
        input1 = 4'd7;
        input2 = 4'd7;
        tick();
        tick();
        checks++;
        if (result !== 8'h00) begin
            failures++;
            $display("[TB] FAIL reset_result actual=%h required=%h", result, 8'h00);
        end
        checks++;
        if (count !== 3'd0) begin
            failures++;
            $display("[TB] FAIL reset_count actual=%0d required=%0d", count, 0);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        logic [7:0] partial [4];
        partial = '{8'hE2, 8'h11, 8'hE8, 8'h14};
        start  = 1'b0;
        input1 = 4'd4;
        input2 = 4'd5;
        tick();
        checks++;
        if (count !== 3'd0 || result !== 8'h05) begin
            failures++;
            $display("[TB] FAIL basic_load actual=%h/%0d required=05/0", result, count);
        end
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (count !== 3'(i + 1) || result !== partial[i]) begin
                failures++;
                $display("[TB] FAIL basic_step%0d actual=%h/%0d required=%h/%0d",
                         i + 1, result, count, partial[i], i + 1);
            end
        end
    endtask

    task automatic test_hold();
        input1 = 4'd7;
        input2 = 4'd7;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (count !== 3'd4 || result !== 8'h14) begin
            failures++;
            $display("[TB] FAIL hold actual=%h/%0d required=14/4", result, count);
        end
    endtask

    task automatic test_products();
        logic [3:0] xs  [7];
        logic [3:0] ys  [7];
        logic [7:0] exp [7];
        xs  = '{4'd0,  4'hE,  4'hC,  4'h8,  4'h8,  4'd7,  4'd7};
        ys  = '{4'd3,  4'd7,  4'hC,  4'h8,  4'd7,  4'h8,  4'd7};
        exp = '{8'h00, 8'hF2, 8'h10, 8'h40, 8'hC8, 8'hC8, 8'h31};
        for (int i = 0; i < 7; i++) begin
            load_and_run(xs[i], ys[i]);
            checks++;
            if (count !== 3'd4 || result !== exp[i]) begin
                failures++;
                $display("[TB] FAIL product%0d actual=%h/%0d required=%h/4",
                         i, result, count, exp[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        start  = 1'b0;
        input1 = 4'd4;
        input2 = 4'd5;
        tick();
        start = 1'b1;
        tick();
        tick();
        checks++;
        if (count !== 3'd2) begin
            failures++;
            $display("[TB] FAIL resetmid_pre actual=%0d required=2", count);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (count !== 3'd0 || result !== 8'h00) begin
            failures++;
            $display("[TB] FAIL resetmid_clear actual=%h/%0d required=00/0", result, count);
        end
        reset = 1'b0;
        load_and_run(4'd3, 4'hD);
        checks++;
        if (count !== 3'd4 || result !== 8'hF7) begin
            failures++;
            $display("[TB] FAIL resetmid_rerun actual=%h/%0d required=f7/4", result, count);
        end
    endtask

    task automatic test_abort();
        start  = 1'b0;
        input1 = 4'd4;
        input2 = 4'd5;
        tick();
        start = 1'b1;
        tick();
        tick();
        start  = 1'b0;
        input1 = 4'd2;
        input2 = 4'd3;
        tick();
        checks++;
        if (count !== 3'd0 || result !== 8'h03) begin
            failures++;
            $display("[TB] FAIL abort_load actual=%h/%0d required=03/0", result, count);
        end
        start = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (count !== 3'd4 || result !== 8'h06) begin
            failures++;
            $display("[TB] FAIL abort_rerun actual=%h/%0d required=06/4", result, count);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_hold();
        test_products();
        test_reset_mid();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
